// File: rtl/ram_dual_port_fifo_ctrl.sv
// ram_dual_port_fifo_ctrl
//   Streaming FIFO / trace-buffer controller wrapped around one dual-port RAM.
//   Port A is write-only (producer side), port B is read-only (consumer side).
//   Reads are launched ahead of demand. A credit-limited skid buffer of depth
//   READ_LATENCY+1 absorbs the port-B latency, which allows one word per cycle.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   in_valid/in_ready/in_data     producer handshake
//   overwrite                     when full, accept the new word and drop the oldest unissued word
//   out_valid/out_ready/out_data  consumer handshake (out_data is the skid head)
//   count                         words accepted and not yet popped
//   dropped                       pulse in the cycle a word is discarded
//   ram_*                         RAM port A (write) / port B (read) connections
module ram_dual_port_fifo_ctrl #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 4,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  overwrite,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  dropped,
  output logic                  ram_clken,
  output logic [ADDR_WIDTH-1:0] ram_address_a,
  output logic [DATA_WIDTH-1:0] ram_data_a,
  output logic                  ram_wren_a,
  output logic [ADDR_WIDTH-1:0] ram_address_b,
  output logic                  ram_wren_b,
  input  logic [DATA_WIDTH-1:0] ram_q_b
);

  localparam int DEPTH      = 2 ** ADDR_WIDTH;
  localparam int SKID_DEPTH = READ_LATENCY + 1;
  localparam int SPW        = $clog2(SKID_DEPTH);
  localparam int SCW        = $clog2(SKID_DEPTH + 1);
  localparam int IFW        = $clog2(READ_LATENCY + 1);
  localparam int CW         = $clog2(2 * SKID_DEPTH + 1);

  logic [ADDR_WIDTH-1:0]   wr_ptr_r;
  logic [ADDR_WIDTH-1:0]   rd_ptr_r;
  logic [ADDR_WIDTH-1:0]   addr_b_r;
  logic [ADDR_WIDTH:0]     count_r;
  logic [ADDR_WIDTH:0]     unissued_r;
  logic [READ_LATENCY-1:0] inflight_r;
  logic [DATA_WIDTH-1:0]   skid_mem_r [SKID_DEPTH];
  logic [SPW-1:0]          skid_wr_r;
  logic [SPW-1:0]          skid_rd_r;
  logic [SCW-1:0]          skid_cnt_r;

  logic            full_s;
  logic            push_s;
  logic            pop_s;
  logic            drop_s;
  logic            issue_s;
  logic            returning_s;
  logic [IFW-1:0]  inflight_cnt_s;
  logic [CW-1:0]   credit_s;

  // Skid pointers wrap at SKID_DEPTH, which need not be a power of two.
  function automatic logic [SPW-1:0] skid_inc(input logic [SPW-1:0] p);
    return (p == SPW'(SKID_DEPTH - 1)) ? SPW'(0) : p + SPW'(1);
  endfunction

  assign full_s      = (count_r == (ADDR_WIDTH+1)'(DEPTH));
  assign in_ready    = !full_s || overwrite;
  // No RAM write while reset is held, even if the producer keeps in_valid high.
  assign push_s      = in_valid && in_ready && !rst;
  assign drop_s      = push_s && full_s;
  assign out_valid   = (skid_cnt_r != SCW'(0));
  assign pop_s       = out_valid && out_ready;
  assign out_data    = skid_mem_r[skid_rd_r];
  // The oldest in-flight read has its data on ram_q_b this cycle.
  assign returning_s = inflight_r[READ_LATENCY-1];
  assign dropped     = drop_s;

  assign count         = count_r;
  assign ram_clken     = 1'b1;
  assign ram_wren_b    = 1'b0;
  assign ram_address_a = wr_ptr_r;
  assign ram_data_a    = in_data;
  assign ram_wren_a    = push_s;
  assign ram_address_b = addr_b_r;

  // Read-issue decision. Credit counts skid slots already promised to reads.
  // A pop in this cycle frees one slot, so sustained throughput is one word per cycle.
  always_comb begin
    inflight_cnt_s = IFW'(0);
    issue_s        = 1'b0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight_cnt_s = inflight_cnt_s + IFW'(inflight_r[i]);
    end
    credit_s = CW'(skid_cnt_r) + CW'(inflight_cnt_s);
    // The address is registered, so a word pushed this cycle reaches port B only
    // in the next cycle. That is after its write has completed.
    if ((unissued_r != (ADDR_WIDTH+1)'(0) || push_s) && !drop_s &&
        (credit_s < CW'(SKID_DEPTH) + CW'(pop_s))) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
  end

  // Pointers, issued-read pipeline and occupancy counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r   <= ADDR_WIDTH'(0);
      rd_ptr_r   <= ADDR_WIDTH'(0);
      addr_b_r   <= ADDR_WIDTH'(0);
      count_r    <= (ADDR_WIDTH+1)'(0);
      unissued_r <= (ADDR_WIDTH+1)'(0);
      inflight_r <= READ_LATENCY'(0);
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + ADDR_WIDTH'(1);
      end
      // A drop skips the oldest unissued word. An issue launches it onto port B.
      if (issue_s || drop_s) begin
        rd_ptr_r <= rd_ptr_r + ADDR_WIDTH'(1);
      end
      if (issue_s) begin
        addr_b_r <= rd_ptr_r;
      end
      inflight_r <= READ_LATENCY'({inflight_r, issue_s});
      unissued_r <= unissued_r + (ADDR_WIDTH+1)'(push_s)
                    - (ADDR_WIDTH+1)'(issue_s) - (ADDR_WIDTH+1)'(drop_s);
      count_r    <= count_r + (ADDR_WIDTH+1)'(push_s)
                    - (ADDR_WIDTH+1)'(pop_s) - (ADDR_WIDTH+1)'(drop_s);
    end
  end

  // Skid buffer pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_wr_r  <= SPW'(0);
      skid_rd_r  <= SPW'(0);
      skid_cnt_r <= SCW'(0);
    end else begin
      if (returning_s) begin
        skid_wr_r <= skid_inc(skid_wr_r);
      end
      if (pop_s) begin
        skid_rd_r <= skid_inc(skid_rd_r);
      end
      skid_cnt_r <= skid_cnt_r + SCW'(returning_s) - SCW'(pop_s);
    end
  end

  // Skid payload. It is not reset because the occupancy qualifies its contents.
  always_ff @(posedge clk) begin
    if (returning_s) begin
      skid_mem_r[skid_wr_r] <= ram_q_b;
    end
  end

endmodule

// File: tb/tb_ram_dual_port_fifo_ctrl.sv
module tb_ram_dual_port_fifo_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        overwrite;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  count;
  logic        dropped;
  logic        ram_clken;
  logic [3:0]  ram_address_a;
  logic [31:0] ram_data_a;
  logic        ram_wren_a;
  logic [3:0]  ram_address_b;
  logic        ram_wren_b;
  logic [31:0] ram_q_b;

  int errors = 0;
  int checks = 0;

  ram_dual_port_fifo_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .overwrite(overwrite),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .dropped(dropped), .ram_clken(ram_clken),
    .ram_address_a(ram_address_a), .ram_data_a(ram_data_a), .ram_wren_a(ram_wren_a),
    .ram_address_b(ram_address_b), .ram_wren_b(ram_wren_b), .ram_q_b(ram_q_b)
  );

  always #5 clk = ~clk;

  // RAM model: the address is launched by a clock edge, and data is valid two cycles
  // later (one register stage after the cycle in which the address is presented).
  logic [31:0] mem [16];
  logic [31:0] q_r;
  always @(posedge clk) begin
    if (ram_wren_a) mem[ram_address_a] <= ram_data_a;
    q_r <= mem[ram_address_b];
  end
  assign ram_q_b = q_r;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; overwrite = 1'b0; in_data = 32'd0;
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD; out_ready = 1'b0; overwrite = 1'b0;
    #3;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (dropped !== 1'b0) begin errors++; $display("FAIL reset_dropped got=%b exp=0", dropped); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (ram_wren_a !== 1'b0) begin errors++; $display("FAIL reset_wren_a got=%b exp=0", ram_wren_a); end
    checks++; if (ram_clken !== 1'b1 || ram_wren_b !== 1'b0) begin errors++; $display("FAIL reset_ties clken=%b wren_b=%b exp=1/0", ram_clken, ram_wren_b); end
    do_reset();
  endtask

  // Single word through an empty buffer: visible three cycles after the push.
  task automatic run_latency(input logic [31:0] word, input string name);
    for (int k = 0; k < 6; k++) begin
      in_valid = (k == 0); in_data = word; out_ready = 1'b1;
      #1;
      if (k == 0) begin
        checks++; if (ram_wren_a !== 1'b1 || ram_address_a !== 4'd0 || ram_data_a !== word) begin
          errors++; $display("FAIL %s_write wren=%b addr=%0d data=%h exp=1/0/%h", name, ram_wren_a, ram_address_a, ram_data_a, word);
        end
      end
      checks++; if (out_valid !== (k == 3)) begin errors++; $display("FAIL %s_valid cyc=%0d got=%b exp=%b", name, k, out_valid, (k == 3)); end
      if (k == 3) begin
        checks++; if (out_data !== word) begin errors++; $display("FAIL %s_data got=%h exp=%h", name, out_data, word); end
      end
      checks++; if (count !== ((k >= 1 && k <= 3) ? 5'd1 : 5'd0)) begin errors++; $display("FAIL %s_count cyc=%0d got=%0d", name, k, count); end
      tick();
    end
  endtask

  task automatic test_latency();
    do_reset();
    run_latency(32'hA5, "latency");
  endtask

  task automatic fill16(input logic ow);
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_data = i; overwrite = ow; out_ready = 1'b0;
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_full_no_overwrite();
    do_reset();
    for (int i = 0; i <= 16; i++) begin
      in_valid = 1'b1; in_data = i; overwrite = 1'b0; out_ready = 1'b0;
      #1;
      checks++; if (in_ready !== (i < 16)) begin errors++; $display("FAIL full_in_ready i=%0d got=%b exp=%b", i, in_ready, (i < 16)); end
      checks++; if (count !== 5'(i)) begin errors++; $display("FAIL full_count i=%0d got=%0d exp=%0d", i, count, i); end
      if (i == 16) begin
        checks++; if (ram_wren_a !== 1'b0) begin errors++; $display("FAIL full_refuse_wren got=%b exp=0", ram_wren_a); end
      end
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();
    for (int j = 0; j < 16; j++) begin
      out_ready = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b1 || out_data !== 32'(j)) begin errors++; $display("FAIL full_drain j=%0d valid=%b data=%0d exp=1/%0d", j, out_valid, out_data, j); end
      checks++; if (count !== 5'(16 - j)) begin errors++; $display("FAIL full_drain_count j=%0d got=%0d exp=%0d", j, count, 16 - j); end
      tick();
    end
    #1;
    checks++; if (out_valid !== 1'b0 || count !== 5'd0) begin errors++; $display("FAIL full_empty valid=%b count=%0d exp=0/0", out_valid, count); end
    out_ready = 1'b0;
  endtask

  task automatic test_overwrite();
    logic [31:0] exp;
    do_reset();
    for (int i = 0; i < 18; i++) begin
      in_valid = 1'b1; in_data = i; overwrite = 1'b1; out_ready = 1'b0;
      #1;
      checks++; if (dropped !== (i >= 16)) begin errors++; $display("FAIL ovw_dropped i=%0d got=%b exp=%b", i, dropped, (i >= 16)); end
      if (i >= 16) begin
        checks++; if (count !== 5'd16 || ram_wren_a !== 1'b1) begin errors++; $display("FAIL ovw_full i=%0d count=%0d wren=%b exp=16/1", i, count, ram_wren_a); end
      end
      tick();
    end
    in_valid = 1'b0;
    #1;
    checks++; if (dropped !== 1'b0 || count !== 5'd16) begin errors++; $display("FAIL ovw_after dropped=%b count=%0d exp=0/16", dropped, count); end
    tick();
    overwrite = 1'b0;
    for (int j = 0; j < 16; j++) begin
      out_ready = 1'b1;
      exp = (j < 3) ? 32'(j) : 32'(j + 2);
      #1;
      checks++; if (out_valid !== 1'b1 || out_data !== exp) begin errors++; $display("FAIL ovw_drain j=%0d valid=%b data=%0d exp=1/%0d", j, out_valid, out_data, exp); end
      tick();
    end
    #1;
    checks++; if (out_valid !== 1'b0 || count !== 5'd0) begin errors++; $display("FAIL ovw_empty valid=%b count=%0d exp=0/0", out_valid, count); end
    out_ready = 1'b0;
  endtask

  task automatic test_toggle();
    int sent, got;
    logic seen, held_v;
    logic [31:0] held_d;
    do_reset();
    sent = 0; got = 0; seen = 1'b0; held_v = 1'b0; held_d = 32'd0;
    for (int c = 0; c < 40; c++) begin
      in_valid = 1'b1; in_data = 32'(sent + 1000); out_ready = (c % 2 == 0); overwrite = 1'b0;
      #1;
      checks++; if (count > 5'd16) begin errors++; $display("FAIL tog_count c=%0d got=%0d max=16", c, count); end
      if (held_v) begin
        checks++; if (out_valid !== 1'b1 || out_data !== held_d) begin errors++; $display("FAIL tog_stable c=%0d valid=%b data=%0d exp=1/%0d", c, out_valid, out_data, held_d); end
      end
      if (seen) begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL tog_gap c=%0d got=%b exp=1", c, out_valid); end
      end
      if (out_valid === 1'b1) begin
        seen = 1'b1;
        checks++; if (out_data !== 32'(got + 1000)) begin errors++; $display("FAIL tog_order c=%0d got=%0d exp=%0d", c, out_data, got + 1000); end
        held_v = !out_ready; held_d = out_data;
        if (out_ready) got++;
      end else begin
        held_v = 1'b0;
      end
      if (in_ready === 1'b1) sent++;
      tick();
    end
    in_valid = 1'b0;
    for (int c = 0; c < 40 && got < sent; c++) begin
      out_ready = 1'b1;
      #1;
      if (out_valid === 1'b1) begin
        checks++; if (out_data !== 32'(got + 1000)) begin errors++; $display("FAIL tog_drain got=%0d exp=%0d", out_data, got + 1000); end
        got++;
      end
      tick();
    end
    #1;
    checks++; if (got !== sent || count !== 5'd0) begin errors++; $display("FAIL tog_total popped=%0d pushed=%0d count=%0d exp count=0", got, sent, count); end
    out_ready = 1'b0;
  endtask

  task automatic test_full_pop_same_cycle();
    logic [31:0] exp;
    do_reset();
    fill16(1'b0);
    repeat (3) tick();
    in_valid = 1'b1; in_data = 32'd99; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0 || ram_wren_a !== 1'b0) begin errors++; $display("FAIL same_refuse in_ready=%b wren=%b exp=0/0", in_ready, ram_wren_a); end
    checks++; if (out_valid !== 1'b1 || out_data !== 32'd0) begin errors++; $display("FAIL same_pop valid=%b data=%0d exp=1/0", out_valid, out_data); end
    tick();
    out_ready = 1'b0;
    #1;
    checks++; if (count !== 5'd15 || in_ready !== 1'b1 || ram_wren_a !== 1'b1) begin errors++; $display("FAIL same_next count=%0d in_ready=%b wren=%b exp=15/1/1", count, in_ready, ram_wren_a); end
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL same_count got=%0d exp=16", count); end
    tick();
    for (int j = 0; j < 16; j++) begin
      out_ready = 1'b1;
      exp = (j < 15) ? 32'(j + 1) : 32'd99;
      #1;
      checks++; if (out_valid !== 1'b1 || out_data !== exp) begin errors++; $display("FAIL same_drain j=%0d valid=%b data=%0d exp=1/%0d", j, out_valid, out_data, exp); end
      tick();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 32'(500 + i); overwrite = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || count !== 5'd0 || dropped !== 1'b0) begin errors++; $display("FAIL midrst valid=%b count=%0d dropped=%b exp=0/0/0", out_valid, count, dropped); end
    overwrite = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    run_latency(32'h1234, "midrst");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_latency();
    test_full_no_overwrite();
    test_overwrite();
    test_toggle();
    test_full_pop_same_cycle();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
